// File: rtl/mii_rx_framer_pkg.sv
// Shared constants and types for the MII receive framer.
package mii_rx_pkg;

  localparam logic [3:0] PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0] SFD_NIB       = 4'hD;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_t;

  // One output FIFO entry; err is only meaningful together with eof.
  typedef struct packed {
    logic       err;
    logic       eof;
    logic       sof;
    logic [7:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/mii_rx_framer_if.sv
// Framed byte stream leaving the receiver: FWFT head plus ready/valid pop.
interface mii_rx_framer_if;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, out_sof, out_eof, out_err, out_valid, input out_ready);
  modport slave  (input out_data, out_sof, out_eof, out_err, out_valid, output out_ready);
endinterface

// File: rtl/mii_rx_framer_fifo.sv
// First-word fall-through FIFO; a push while full is dropped even if a pop happens.
module mii_rx_fifo #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage write, no reset needed on the array.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer update; the extra MSB distinguishes full from empty across wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/mii_rx_framer.sv
// MII/GMII receive framer: sync, preamble strip, byte assembly, FCS delay line, FIFO.
//
// state   | meaning
// IDLE    | waiting for receive enable
// PRE     | inside preamble, waiting for SFD
// DATA    | assembling frame bytes into the delay line
// DROP    | discarding the rest of a bad/truncated frame until enable falls
module mii_rx_framer
  import mii_rx_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 2048,
  parameter bit STRIP_FCS  = 1'b1,
  parameter int MIN_LEN    = 18,
  parameter int MAX_LEN    = 1522
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mii_clk,
  input  logic              mii_en,
  input  logic [DATA_W-1:0] mii_d,
  mii_rx_framer_if.master   out_if,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [15:0]       frame_len,
  output logic [15:0]       drop_cnt
);
  // Delay line holds the FCS bytes back, the last stage is the byte next in line.
  localparam int PIPE_N = (STRIP_FCS ? 4 : 0) + 1;

  logic [1:0]        clk_sync;
  logic [1:0]        en_sync;
  logic [DATA_W-1:0] d_s1, d_s2;
  logic              clk_prev;
  logic              sample;

  rx_state_t         state;
  logic [15:0]       len;
  logic [3:0]        nib_lo;
  logic              nib_half;
  logic [2:0]        fill;
  logic              sof_pend;
  logic [7:0]        pipe [PIPE_N];
  logic [7:0]        stage;
  logic              wr_en;
  fifo_entry_t       wr_entry;

  logic              s_pre, s_sfd, byte_done, end_err;
  logic [7:0]        new_byte;
  logic [15:0]       drop_inc;
  logic              fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_rd;
  fifo_entry_t       head;

  // Two-flop capture of the PHY pins plus edge history of the synced clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '0;
      en_sync  <= '0;
      d_s1     <= '0;
      d_s2     <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], mii_clk};
      en_sync  <= {en_sync[0], mii_en};
      d_s1     <= mii_d;
      d_s2     <= d_s1;
      clk_prev <= clk_sync[1];
    end
  end

  assign sample = clk_sync[1] & ~clk_prev;

  if (DATA_W == 4) begin : g_nib
    assign s_pre     = (d_s2 == PREAMBLE_NIB);
    assign s_sfd     = (d_s2 == SFD_NIB);
    assign new_byte  = {d_s2, nib_lo};
    assign byte_done = nib_half;
  end else begin : g_byte
    assign s_pre     = (d_s2 == PREAMBLE_BYTE);
    assign s_sfd     = (d_s2 == SFD_BYTE);
    assign new_byte  = d_s2;
    assign byte_done = 1'b1;
  end

  assign stage    = pipe[PIPE_N-1];
  assign end_err  = (len < 16'(MIN_LEN)) | nib_half;
  assign drop_inc = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;

  // Frame FSM, advanced only on synced mii_clk rising samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      nib_lo    <= '0;
      nib_half  <= 1'b0;
      fill      <= '0;
      sof_pend  <= 1'b0;
      for (int i = 0; i < PIPE_N; i++) pipe[i] <= '0;
      wr_en     <= 1'b0;
      wr_entry  <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      frame_len <= '0;
      drop_cnt  <= '0;
    end else begin
      wr_en     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (sample) begin
        case (state)
          ST_IDLE: begin
            if (en_sync[1]) begin
              state    <= s_pre ? ST_PRE : ST_DROP;
              len      <= '0;
              fill     <= '0;
              nib_half <= 1'b0;
              sof_pend <= 1'b1;
            end
          end
          ST_PRE: begin
            if (!en_sync[1])  state <= ST_IDLE;
            else if (s_sfd)   state <= ST_DATA;
            else if (!s_pre)  state <= ST_DROP;
          end
          ST_DATA: begin
            if (!en_sync[1]) begin
              frame_len <= len;
              state     <= ST_IDLE;
              if (fill != 3'(PIPE_N)) begin
                frame_err <= 1'b1;
              end else if (fifo_full) begin
                drop_cnt  <= drop_inc;
                frame_err <= 1'b1;
              end else begin
                wr_en     <= 1'b1;
                wr_entry  <= '{err: end_err, eof: 1'b1, sof: sof_pend, data: stage};
                frame_ok  <= ~end_err;
                frame_err <= end_err;
              end
            end else if (byte_done) begin
              nib_half <= 1'b0;
              if (len != 16'hFFFF) len <= len + 16'd1;
              if (len == 16'(MAX_LEN)) begin
                // Giant: close the frame on the stage byte, drop the remainder.
                state <= ST_DROP;
                if (fill == 3'(PIPE_N)) begin
                  if (fifo_full) drop_cnt <= drop_inc;
                  else begin
                    wr_en    <= 1'b1;
                    wr_entry <= '{err: 1'b1, eof: 1'b1, sof: sof_pend, data: stage};
                  end
                end
              end else begin
                pipe[0] <= new_byte;
                for (int i = 1; i < PIPE_N; i++) pipe[i] <= pipe[i-1];
                if (fill != 3'(PIPE_N)) begin
                  fill <= fill + 3'd1;
                end else if (fifo_full) begin
                  drop_cnt <= drop_inc;
                  state    <= ST_DROP;
                end else begin
                  wr_en    <= 1'b1;
                  wr_entry <= '{err: 1'b0, eof: 1'b0, sof: sof_pend, data: stage};
                  sof_pend <= 1'b0;
                end
              end
            end else begin
              nib_lo   <= d_s2[3:0];
              nib_half <= 1'b1;
            end
          end
          ST_DROP: begin
            if (!en_sync[1]) begin
              frame_err <= 1'b1;
              frame_len <= len;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  mii_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (out_if.out_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head is forced to zero while empty so the stream reads 0 after reset.
  assign head              = fifo_empty ? '0 : fifo_entry_t'(fifo_rd);
  assign out_if.out_data   = head.data;
  assign out_if.out_sof    = head.sof;
  assign out_if.out_eof    = head.eof;
  assign out_if.out_err    = head.err;
  assign out_if.out_valid  = ~fifo_empty;
endmodule

// File: tb/tb_mii_rx_framer.sv
// Scoreboard bench: two framer instances share one MII pin set.
// u_a: DATA_W=4, FIFO_DEPTH=16, STRIP_FCS=1, MAX_LEN=64; u_b: STRIP_FCS=0, defaults otherwise.
module tb_mii_rx_framer;
  import mii_rx_pkg::*;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic        is_err;
    logic        chk_len;
    logic [15:0] len;
  } pulse_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mii_clk, mii_en;
  logic [3:0]  mii_d;
  logic        ok_a, err_a, ok_b, err_b;
  logic [15:0] len_a, len_b, drop_a, drop_b;

  mii_rx_framer_if if_a ();
  mii_rx_framer_if if_b ();

  mii_rx_framer #(.DATA_W(4), .FIFO_DEPTH(16), .STRIP_FCS(1'b1), .MIN_LEN(18), .MAX_LEN(64)) u_a (
    .clk(clk), .rst(rst), .mii_clk(mii_clk), .mii_en(mii_en), .mii_d(mii_d), .out_if(if_a),
    .frame_ok(ok_a), .frame_err(err_a), .frame_len(len_a), .drop_cnt(drop_a));

  mii_rx_framer #(.DATA_W(4), .FIFO_DEPTH(2048), .STRIP_FCS(1'b0), .MIN_LEN(18), .MAX_LEN(1522)) u_b (
    .clk(clk), .rst(rst), .mii_clk(mii_clk), .mii_en(mii_en), .mii_d(mii_d), .out_if(if_b),
    .frame_ok(ok_b), .frame_err(err_b), .frame_len(len_b), .drop_cnt(drop_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pops_a = 0, pops_b = 0;
  int drop_exp_a = 0;
  bit hold_a = 1'b0, hold_b = 1'b0;
  logic [10:0] exp_a[$], exp_b[$];
  pulse_t      pul_a[$], pul_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  task automatic check_pulse(input string tag, input logic ok, input logic er,
                             input logic [15:0] len, input pulse_t p);
    chk({tag, " pulse kind"}, {30'd0, ok, er}, {30'd0, ~p.is_err, p.is_err});
    if (p.chk_len) chk({tag, " frame_len"}, {16'd0, len}, {16'd0, p.len});
  endtask

  // Reference model: a frame of n bytes, optional trailing nibble, per-instance limits.
  task automatic model_one(input int inst, input byte_q_t data, input bit odd, input bit bad,
                           input bit nofill);
    int dly   = (inst == 0) ? 4 : 0;
    int mx    = (inst == 0) ? 64 : 1522;
    int depth = (inst == 0) ? 16 : 2048;
    int n     = data.size();
    int keep, outn;
    bit giant, err;
    logic [10:0] ents[$];
    pulse_t p;
    if (bad) begin
      p = '{is_err: 1'b1, chk_len: 1'b0, len: 16'd0};
    end else begin
      giant = (n > mx);
      keep  = giant ? mx : n;
      err   = giant || (n < 18) || odd;
      outn  = keep - dly;
      if (outn < 0) outn = 0;
      if (nofill && outn > depth) begin
        for (int i = 0; i < depth; i++) ents.push_back({1'b0, 1'b0, (i == 0), data[i]});
        if (inst == 0) drop_exp_a++;
        p = '{is_err: 1'b1, chk_len: 1'b0, len: 16'd0};
      end else begin
        for (int i = 0; i < outn; i++)
          ents.push_back({(i == outn - 1) && err, (i == outn - 1), (i == 0), data[i]});
        p = '{is_err: err, chk_len: 1'b1, len: giant ? 16'(mx + 1) : 16'(n)};
      end
    end
    foreach (ents[i]) begin
      if (inst == 0) exp_a.push_back(ents[i]);
      else           exp_b.push_back(ents[i]);
    end
    if (inst == 0) pul_a.push_back(p);
    else           pul_b.push_back(p);
  endtask

  task automatic mii_cycle(input logic en, input logic [3:0] d);
    @(posedge clk); #1;
    mii_clk = 1'b0; mii_en = en; mii_d = d;
    @(posedge clk); @(posedge clk); #1;
    mii_clk = 1'b1;
    @(posedge clk);
  endtask

  task automatic send_frame(input byte_q_t data, input int npre, input bit bad, input bit odd,
                            input logic [3:0] xnib, input bit fall);
    for (int i = 0; i < npre; i++) mii_cycle(1'b1, 4'h5);
    mii_cycle(1'b1, bad ? 4'h7 : 4'hD);
    foreach (data[i]) begin
      mii_cycle(1'b1, data[i][3:0]);
      mii_cycle(1'b1, data[i][7:4]);
    end
    if (odd) mii_cycle(1'b1, xnib);
    if (fall) repeat (3) mii_cycle(1'b0, 4'h0);
  endtask

  task automatic run_frame(input byte_q_t data, input int npre, input bit bad, input bit odd,
                           input bit nofill_a);
    model_one(0, data, odd, bad, nofill_a);
    model_one(1, data, odd, bad, 1'b0);
    send_frame(data, npre, bad, odd, 4'($urandom_range(15)), 1'b1);
  endtask

  function automatic byte_q_t rand_frame(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  function automatic byte_q_t test1_frame();
    byte_q_t q;
    q = '{8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc,
          8'h12, 8'h34};
    for (int i = 0; i < 30; i++) q.push_back(8'(i + 8'h40));
    q.push_back(8'h64); q.push_back(8'h90); q.push_back(8'h02); q.push_back(8'hfb);
    return q;
  endfunction

  task automatic drain(input string tag);
    int cyc = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || pul_a.size() != 0 || pul_b.size() != 0 ||
            if_a.out_valid || if_b.out_valid) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    chk({tag, " drain timeout"}, (cyc >= 20000), 0);
  endtask

  // Random downstream backpressure, suppressed while an instance is held.
  initial begin
    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if_a.out_ready = !hold_a && ($urandom_range(3) != 0);
      if_b.out_ready = !hold_b && ($urandom_range(3) != 0);
    end
  end

  // Monitor: pop and compare on every handshake and every frame pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_a.out_valid && if_a.out_ready) begin
          pops_a++;
          if (exp_a.size() == 0)
            unexpected("byte a", {21'd0, if_a.out_err, if_a.out_eof, if_a.out_sof, if_a.out_data});
          else
            chk("byte a", {21'd0, if_a.out_err, if_a.out_eof, if_a.out_sof, if_a.out_data},
                {21'd0, exp_a.pop_front()});
        end
        if (if_b.out_valid && if_b.out_ready) begin
          pops_b++;
          if (exp_b.size() == 0)
            unexpected("byte b", {21'd0, if_b.out_err, if_b.out_eof, if_b.out_sof, if_b.out_data});
          else
            chk("byte b", {21'd0, if_b.out_err, if_b.out_eof, if_b.out_sof, if_b.out_data},
                {21'd0, exp_b.pop_front()});
        end
        if (ok_a || err_a) begin
          if (pul_a.size() == 0) unexpected("pulse a", {30'd0, ok_a, err_a});
          else check_pulse("a", ok_a, err_a, len_a, pul_a.pop_front());
        end
        if (ok_b || err_b) begin
          if (pul_b.size() == 0) unexpected("pulse b", {30'd0, ok_b, err_b});
          else check_pulse("b", ok_b, err_b, len_b, pul_b.pop_front());
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t f;
    int p0a, p0b, wait_cyc;

    rst = 1'b1; mii_clk = 1'b0; mii_en = 1'b0; mii_d = 4'h0;
    repeat (4) @(negedge clk);
    chk("reset valid a", if_a.out_valid, 0);
    chk("reset valid b", if_b.out_valid, 0);
    chk("reset head a", {if_a.out_err, if_a.out_eof, if_a.out_sof, if_a.out_data}, 0);
    chk("reset pulses", {ok_a, err_a, ok_b, err_b}, 0);
    chk("reset frame_len a", len_a, 0);
    chk("reset drop_cnt a", drop_a, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) mii_cycle(1'b0, 4'h0);

    // Reference frame, stripped on u_a and passed through on u_b.
    p0a = pops_a; p0b = pops_b;
    run_frame(test1_frame(), 15, 1'b0, 1'b0, 1'b0);
    drain("t1");
    chk("t1 byte count a", pops_a - p0a, 44);
    chk("t1 byte count b", pops_b - p0b, 48);

    // Short frame, odd nibble, bad preamble.
    run_frame(rand_frame(10), 15, 1'b0, 1'b0, 1'b0);
    run_frame(test1_frame(), 15, 1'b0, 1'b1, 1'b0);
    run_frame(rand_frame(12), 2, 1'b1, 1'b0, 1'b0);

    // Length boundaries: min, strip window, empty, max.
    run_frame(rand_frame(17), 3, 1'b0, 1'b0, 1'b0);
    run_frame(rand_frame(18), 7, 1'b0, 1'b0, 1'b0);
    run_frame(rand_frame(4), 1, 1'b0, 1'b0, 1'b0);
    run_frame(rand_frame(5), 1, 1'b0, 1'b0, 1'b0);
    run_frame(rand_frame(0), 5, 1'b0, 1'b0, 1'b0);
    run_frame(rand_frame(64), 15, 1'b0, 1'b0, 1'b0);
    run_frame(rand_frame(65), 15, 1'b0, 1'b0, 1'b0);
    drain("boundary");

    // Overflow on the 16-deep instance with its consumer stalled.
    hold_a = 1'b1;
    run_frame(test1_frame(), 15, 1'b0, 1'b0, 1'b1);
    wait_cyc = 0;
    while (pul_a.size() != 0 && wait_cyc < 2000) begin @(posedge clk); wait_cyc++; end
    chk("ovf pulse timeout", (wait_cyc >= 2000), 0);
    @(negedge clk);
    chk("ovf drop_cnt a", drop_a, drop_exp_a);
    chk("ovf drop_cnt b", drop_b, 0);
    chk("ovf valid a", if_a.out_valid, 1);
    hold_a = 1'b0;
    run_frame(rand_frame(30), 15, 1'b0, 1'b0, 1'b0);
    drain("ovf");

    // Random traffic.
    for (int k = 0; k < 20; k++) begin
      run_frame(rand_frame($urandom_range(0, 80)), $urandom_range(1, 15),
                ($urandom_range(9) == 0), ($urandom_range(7) == 0), 1'b0);
    end
    drain("random");

    // Reset in the middle of a frame: FIFOs cleared, counters cleared, no pulse.
    hold_a = 1'b1; hold_b = 1'b1;
    send_frame(rand_frame(10), 15, 1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    chk("pre-reset valid a", if_a.out_valid, 1);
    chk("pre-reset valid b", if_b.out_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; mii_en = 1'b0;
    repeat (4) mii_cycle(1'b0, 4'h0);
    @(negedge clk);
    chk("post-reset valid a", if_a.out_valid, 0);
    chk("post-reset valid b", if_b.out_valid, 0);
    chk("post-reset drop_cnt a", drop_a, 0);
    chk("post-reset frame_len a", len_a, 0);
    chk("post-reset frame_len b", len_b, 0);
    chk("leftover expectations", exp_a.size() + exp_b.size() + pul_a.size() + pul_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
